// File: rtl/frogger_lane_engine.sv
// Multi-lane Frogger obstacle engine: car motion, frog/car collision with a hit-hold freeze, and level tracking.
// Optional build macro FROGGER_WRAP_COLLISION_EN makes the overlap distance wrap around the horizontal screen edge.
module frogger_lane_engine #(
    parameter int         NUM_LANES      = 4,
    parameter int         TILE_SIZE      = 32,
    parameter int         H_VISIBLE_AREA = 640,
    parameter int         LANE_Y_BASE    = 64,
    parameter logic [7:0] DIR_MASK       = 8'b0000_1010,
    parameter int         BASE_PERIOD    = 400000,
    parameter int         LEVEL_STEP     = 50000,
    parameter int         MIN_PERIOD     = 50000,
    parameter int         LANE_SKEW      = 0,
    parameter int         MAX_LEVEL      = 7,
    parameter int         HIT_HOLD       = 25000000
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_L,
    input  logic [9:0]              i_Frog_X,
    input  logic [9:0]              i_Frog_Y,
    input  logic                    i_Level_Up,
    output logic [10*NUM_LANES-1:0] o_Car_X,
    output logic                    o_Has_Collided,
    output logic [2:0]              o_Hit_Lane,
    output logic [2:0]              o_Level,
    output logic                    o_Frozen
);
    localparam logic [9:0]  X_LAST    = 10'(H_VISIBLE_AREA - 1);
    localparam logic [9:0]  TILE_W    = 10'(TILE_SIZE);
    localparam int          CAR_GAP   = H_VISIBLE_AREA / NUM_LANES;
    localparam logic [23:0] BASE_P    = 24'(BASE_PERIOD);
    localparam logic [23:0] STEP_P    = 24'(LEVEL_STEP);
    localparam logic [23:0] MIN_P     = 24'(MIN_PERIOD);
    localparam logic [23:0] SKEW_P    = 24'(LANE_SKEW);
    localparam logic [2:0]  LEVEL_TOP = 3'(MAX_LEVEL);
    localparam logic [24:0] HOLD_LOAD = 25'(HIT_HOLD - 1);
`ifdef FROGGER_WRAP_COLLISION_EN
    localparam logic [9:0]  X_SPAN    = 10'(H_VISIBLE_AREA);
`endif

    typedef enum logic {RUN, HIT} state_t;

    state_t      state, state_nxt;
    logic [9:0]  car_x [NUM_LANES];
    logic [23:0] presc [NUM_LANES];
    logic [23:0] lane_period [NUM_LANES];
    logic [24:0] hold_cnt;
    logic        any_overlap;
    logic [2:0]  hit_idx;
    logic        take_hit, level_bump, advance, resume;

    // Clamp happens before the subtraction so high levels never underflow.
    function automatic logic [23:0] clamp_period(input logic [2:0] level);
        logic [23:0] reduction;
        reduction = 24'(level) * STEP_P;
        if (reduction >= BASE_P || (BASE_P - reduction) < MIN_P)
            return MIN_P;
        return BASE_P - reduction;
    endfunction

    function automatic logic [2:0] sat_level_inc(input logic [2:0] level);
        return (level >= LEVEL_TOP) ? LEVEL_TOP : level + 3'd1;
    endfunction

    function automatic logic close_enough(input logic [9:0] a, input logic [9:0] b);
        logic [9:0] d;
        d = (a >= b) ? a - b : b - a;
`ifdef FROGGER_WRAP_COLLISION_EN
        if (d < X_SPAN && (X_SPAN - d) < d)
            d = X_SPAN - d;
`endif
        return d < TILE_W;
    endfunction

    function automatic logic [9:0] step_x(input logic [9:0] x, input logic reverse);
        if (reverse)
            return (x == 10'd0) ? X_LAST : x - 10'd1;
        return (x == X_LAST) ? 10'd0 : x + 10'd1;
    endfunction

    always_comb begin
        for (int k = 0; k < NUM_LANES; k++) begin
            lane_period[k]    = clamp_period(o_Level) + 24'(k) * SKEW_P;
            o_Car_X[10*k +: 10] = car_x[k];
        end
    end

    // Scan from the top lane down so the lowest overlapping index is the one left standing.
    always_comb begin
        any_overlap = 1'b0;
        hit_idx     = 3'd0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (i_Frog_Y == 10'(LANE_Y_BASE + k*TILE_SIZE) && close_enough(i_Frog_X, car_x[k])) begin
                any_overlap = 1'b1;
                hit_idx     = 3'(k);
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) state <= RUN;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        take_hit   = 1'b0;
        level_bump = 1'b0;
        advance    = 1'b0;
        resume     = 1'b0;
        case (state)
            RUN: begin
                if (any_overlap) begin
                    state_nxt = HIT;
                    take_hit  = 1'b1;
                end else if (i_Level_Up) begin
                    level_bump = 1'b1;
                end else begin
                    advance = 1'b1;
                end
            end
            HIT: begin
                if (hold_cnt == 25'd0) begin
                    state_nxt = RUN;
                    resume    = 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    assign o_Frozen = (state == HIT);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                car_x[k] <= 10'(k*CAR_GAP);
                presc[k] <= 24'd0;
            end
            hold_cnt       <= 25'd0;
            o_Has_Collided <= 1'b0;
            o_Hit_Lane     <= 3'd0;
            o_Level        <= 3'd0;
        end else begin
            o_Has_Collided <= take_hit;
            if (take_hit) begin
                o_Hit_Lane <= hit_idx;
                hold_cnt   <= HOLD_LOAD;
            end else if (state == HIT && hold_cnt != 25'd0) begin
                hold_cnt <= hold_cnt - 25'd1;
            end

            if (level_bump) begin
                o_Level <= sat_level_inc(o_Level);
                for (int k = 0; k < NUM_LANES; k++) begin
                    car_x[k] <= 10'(k*CAR_GAP);
                    presc[k] <= 24'd0;
                end
            end else if (resume) begin
                for (int k = 0; k < NUM_LANES; k++)
                    presc[k] <= 24'd0;
            end else if (advance) begin
                for (int k = 0; k < NUM_LANES; k++) begin
                    if (presc[k] >= lane_period[k] - 24'd1) begin
                        presc[k] <= 24'd0;
                        car_x[k] <= step_x(car_x[k], DIR_MASK[k]);
                    end else begin
                        presc[k] <= presc[k] + 24'd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_frogger_lane_engine.sv
// Self-checking bench for frogger_lane_engine: directed edge cases plus randomized frog/level stimulus against a behavioural model.
module tb_frogger_lane_engine;
    localparam int NL = 4;
    localparam int TS = 32;
    localparam int HV = 640;
    localparam int LY = 64;
    localparam int BP = 4;
    localparam int LS = 1;
    localparam int MP = 2;
    localparam int SK = 0;
    localparam int ML = 7;
    localparam int HH = 8;
    localparam logic [7:0] DM = 8'b0000_1010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  frog_x = 10'd0;
    logic [9:0]  frog_y = 10'd0;
    logic        lvl_up = 1'b0;
    logic [39:0] car_bus;
    logic        coll;
    logic [2:0]  hit_lane;
    logic [2:0]  level;
    logic        frozen;

    int n_tests = 0;
    int n_fail  = 0;
    bit checking = 1'b0;

    int m_x [NL];
    int m_level, m_hit_lane, m_hold, m_phase;
    bit m_frozen, m_coll;

    frogger_lane_engine #(
        .NUM_LANES(NL), .TILE_SIZE(TS), .H_VISIBLE_AREA(HV), .LANE_Y_BASE(LY),
        .DIR_MASK(DM), .BASE_PERIOD(BP), .LEVEL_STEP(LS), .MIN_PERIOD(MP),
        .LANE_SKEW(SK), .MAX_LEVEL(ML), .HIT_HOLD(HH)
    ) dut (
        .i_Clk(clk),
        .i_Rst_L(rst_n),
        .i_Frog_X(frog_x),
        .i_Frog_Y(frog_y),
        .i_Level_Up(lvl_up),
        .o_Car_X(car_bus),
        .o_Has_Collided(coll),
        .o_Hit_Lane(hit_lane),
        .o_Level(level),
        .o_Frozen(frozen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int period(input int lvl, input int k);
        int p;
        p = BP - lvl*LS;
        if (p < MP) p = MP;
        return p + k*SK;
    endfunction

    function automatic bit overlaps(input int fx, input int fy, input int cx, input int k);
        int d;
        if (fy != LY + k*TS) return 1'b0;
        d = (fx > cx) ? fx - cx : cx - fx;
`ifdef FROGGER_WRAP_COLLISION_EN
        if (d < HV && HV - d < d) d = HV - d;
`endif
        return d < TS;
    endfunction

    task automatic place_cars();
        for (int k = 0; k < NL; k++) m_x[k] = k * (HV / NL);
    endtask

    task automatic model_reset();
        place_cars();
        m_level = 0; m_hit_lane = 0; m_hold = 0; m_phase = 0;
        m_frozen = 1'b0; m_coll = 1'b0;
    endtask

    task automatic model_step();
        int hit;
        hit = -1;
        m_coll = 1'b0;
        if (m_frozen) begin
            if (m_hold == 0) begin
                m_frozen = 1'b0;
                m_phase  = 0;
            end else begin
                m_hold--;
            end
        end else begin
            for (int k = 0; k < NL; k++)
                if (hit < 0 && overlaps(int'(frog_x), int'(frog_y), m_x[k], k)) hit = k;
            if (hit >= 0) begin
                m_frozen = 1'b1; m_coll = 1'b1; m_hit_lane = hit; m_hold = HH - 1;
            end else if (lvl_up) begin
                m_level = (m_level + 1 > ML) ? ML : m_level + 1;
                place_cars();
                m_phase = 0;
            end else begin
                m_phase++;
                for (int k = 0; k < NL; k++)
                    if (m_phase % period(m_level, k) == 0)
                        m_x[k] = DM[k] ? (m_x[k] + HV - 1) % HV : (m_x[k] + 1) % HV;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    always @(negedge clk) begin
        if (checking) begin
            for (int k = 0; k < NL; k++)
                chk($sformatf("car%0d_x", k), int'(car_bus[10*k +: 10]), m_x[k]);
            chk("collided", int'(coll), int'(m_coll));
            chk("hit_lane", int'(hit_lane), m_hit_lane);
            chk("level", int'(level), m_level);
            chk("frozen", int'(frozen), int'(m_frozen));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int car(input int k);
        return int'(car_bus[10*k +: 10]);
    endfunction

    task automatic wait_unfrozen();
        int guard;
        guard = 0;
        while (frozen && guard < 40) begin
            tick(1);
            guard++;
        end
        chk("unfreeze_timeout", int'(frozen), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, guard, v, kk;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_car0", car(0), 0);
        chk("rst_car3", car(3), 480);
        rst_n = 1'b1;
        checking = 1'b1;
        chk("rst_bus", int'(car_bus == {10'd480, 10'd320, 10'd160, 10'd0}), 1);
        chk("rst_flags", int'({coll, frozen, hit_lane, level}), 0);

        // Free-running motion and edge wrap at level 0 (period 4)
        tick(40);
        chk("t40_car0", car(0), 10);
        chk("t40_car1", car(1), 150);
        chk("t40_car2", car(2), 330);
        chk("t40_car3", car(3), 470);
        tick(600);
        chk("car1_at0", car(1), 0);
        tick(3);
        chk("car1_hold", car(1), 0);
        tick(1);
        chk("car1_wrap", car(1), 639);
        tick(1912);
        chk("car0_at639", car(0), 639);
        tick(3);
        chk("car0_hold", car(0), 639);
        tick(1);
        chk("car0_wrap", car(0), 0);

        // Collision boundary on lane 0
        frog_y = 10'(LY);
        frog_x = 10'(m_x[0] + 32);
        tick(1);
        chk("edge32_nohit", int'(coll), 0);
        frog_x = 10'(m_x[0] + 31);
        tick(1);
        chk("edge31_hit", int'(coll), 1);
        chk("edge31_lane", int'(hit_lane), 0);
        frog_y = 10'd0;
        cnt = 1;
        guard = 0;
        while (guard < 20) begin
            tick(1);
            guard++;
            if (frozen) cnt++;
            else break;
        end
        chk("frozen_len", cnt, 8);
        chk("car0_held", car(0), 0);
        tick(4);
        chk("car0_resume", car(0), 1);

        // Level progression and period clamp
        lvl_up = 1'b1; tick(1); lvl_up = 1'b0;
        chk("lvl1", int'(level), 1);
        chk("lvl1_car0_reset", car(0), 0);
        chk("lvl1_car1_reset", car(1), 160);
        tick(2);
        chk("p3_not_yet", car(0), 0);
        tick(1);
        chk("p3_step", car(0), 1);
        repeat (2) begin lvl_up = 1'b1; tick(1); lvl_up = 1'b0; end
        chk("lvl3", int'(level), 3);
        tick(2);
        chk("p2_step", car(0), 1);

        // Overlap and level-up together: the hit wins
        frog_y = 10'(LY);
        frog_x = 10'(m_x[0] + 5);
        lvl_up = 1'b1;
        tick(1);
        lvl_up = 1'b0;
        frog_y = 10'd0;
        chk("simul_hit", int'(coll), 1);
        chk("simul_level", int'(level), 3);
        wait_unfrozen();
        repeat (7) begin lvl_up = 1'b1; tick(1); lvl_up = 1'b0; end
        chk("lvl_sat", int'(level), 7);

        // Car straddling the right edge versus frog near the left edge
        tick(1260);
        chk("car0_630", car(0), 630);
        frog_y = 10'(LY);
        frog_x = 10'd10;
        tick(1);
        frog_y = 10'd0;
`ifdef FROGGER_WRAP_COLLISION_EN
        chk("wrap_hit", int'(coll), 1);
`else
        chk("wrap_nohit", int'(coll), 0);
`endif
        wait_unfrozen();

        // Randomized frog placement and level pulses
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 50) begin
                kk = int'($urandom_range(0, NL - 1));
                v = m_x[kk] + int'($urandom_range(0, 80)) - 40;
                if (v < 0) v = 0;
                if (v > 1023) v = 1023;
                frog_y = 10'(LY + kk*TS);
                frog_x = 10'(v);
            end else begin
                frog_y = 10'($urandom_range(0, 255));
                frog_x = 10'($urandom_range(0, 1023));
            end
            lvl_up = ($urandom_range(0, 39) == 0);
            tick(1);
        end
        lvl_up = 1'b0;
        frog_y = 10'd0;
        wait_unfrozen();

        // Reset dropped in the middle of a hit hold
        frog_y = 10'(LY + 2*TS);
        frog_x = 10'(m_x[2]);
        tick(1);
        frog_y = 10'd0;
        chk("lane2_hit", int'(coll), 1);
        chk("lane2_idx", int'(hit_lane), 2);
        guard = 0;
        while (m_hold != 4 && guard < 20) begin
            tick(1);
            guard++;
        end
        chk("hold4_reached", m_hold, 4);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_bus", int'(car_bus == {10'd480, 10'd320, 10'd160, 10'd0}), 1);
        chk("arst_level", int'(level), 0);
        chk("arst_frozen", int'(frozen), 0);
        chk("arst_lane", int'(hit_lane), 0);
        chk("arst_coll", int'(coll), 0);
        tick(2);
        rst_n = 1'b1;
        tick(10);
        chk("post_rst_car0", car(0), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
